bram_stream_loader: RTL and testbench

Upstream feeder for the user-application BRAM stage. Accepts an 8-bit valid/ready byte stream from the host receive path, packs four bytes little-endian into 32-bit words and writes them sequentially into the input BRAM from address 0. When the programmed frame length has been written it pulses `frame_done` so the downstream stage can begin its read sweep.

---
 rtl/bram_stream_loader_pkg.sv | 18 +
 rtl/bram_stream_loader_if.sv | 30 +++
 rtl/bram_stream_loader_byte_packer.sv | 31 +++
 rtl/bram_stream_loader.sv | 135 +++++++++++++
 tb/tb_bram_stream_loader.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bram_stream_loader_pkg.sv
// Shared constants and state encoding for the BRAM stream loader.
// Build option: LOADER_CHECKSUM_EN adds a trailing checksum byte per frame.
package loader_pkg;

  localparam int BYTE_LANES = 4;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 8 * BYTE_LANES;

  localparam logic [BYTE_LANES-1:0] WE_ALL = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/bram_stream_loader_if.sv
// Byte stream input and BRAM write port of the loader, bundled as one interface.
// slave = loader side, master = stream source / BRAM model side.
interface bram_stream_loader_if
  import loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  // Stream handshake: a byte transfers on a rising clock edge where s_valid & s_ready;
  // s_valid must hold with stable s_data until accepted, s_ready never looks at s_valid.
  logic [7:0]            s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic [ADDR_W-1:0]     bram_addr;
  logic [DATA_W-1:0]     bram_din;
  logic [BYTE_LANES-1:0] bram_we;
  logic                  bram_en;

  modport master (
    output s_data, s_valid,
    input  s_ready, bram_addr, bram_din, bram_we, bram_en
  );

  modport slave (
    input  s_data, s_valid,
    output s_ready, bram_addr, bram_din, bram_we, bram_en
  );

endinterface

// File: rtl/bram_stream_loader_byte_packer.sv
// byte_packer: collects bytes little-endian into a word; word_valid pulses with the
// fourth byte, when word already holds that byte in bits 31:24.
module byte_packer
  import loader_pkg::*;
(
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    clear,
  input  logic                    in_valid,
  input  logic [7:0]              in_data,
  output logic                    word_valid,
  output logic [8*BYTE_LANES-1:0] word
);

  logic [1:0]                    lane;
  logic [8*(BYTE_LANES-1)-1:0]   shreg;

  always_ff @(posedge clock) begin
    if (!resetn || clear) begin
      lane  <= '0;
      shreg <= '0;
    end else if (in_valid) begin
      lane  <= lane + 2'd1;
      shreg <= {in_data, shreg[8*(BYTE_LANES-1)-1:8]};
    end
  end

  assign word_valid = in_valid && (lane == 2'd3);
  assign word       = {in_data, shreg};

endmodule

// File: rtl/bram_stream_loader.sv
// bram_stream_loader: writes a packed byte stream to BRAM words 0..frame_last, then pulses
// frame_done. Define LOADER_CHECKSUM_EN to accept and check a trailing mod-256 sum byte.
module bram_stream_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                clock,
  input  logic                resetn,
  bram_stream_loader_if.slave bus,
  input  logic                start,
  input  logic [ADDR_W-1:0]   frame_last,
  output logic                busy,
  output logic                frame_done,
  output logic [ADDR_W:0]     words_written,
  output logic                chk_err
);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] FILL  = ST_FILL;
  localparam logic [1:0] DONE  = ST_DONE;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [1:0] CHECK = ST_CHECK;
`endif

  logic [1:0]              state;
  logic [ADDR_W-1:0]       last_idx;
  logic [ADDR_W-1:0]       word_idx;
  logic                    hs;
  logic                    word_valid;
  logic [8*BYTE_LANES-1:0] word;

  always_comb begin
    bus.s_ready = (state == FILL);
`ifdef LOADER_CHECKSUM_EN
    if (state == CHECK) bus.s_ready = 1'b1;
`endif
  end

  assign hs = bus.s_valid & bus.s_ready;

  // Held clear while idle, so every frame starts at lane 0 and a reset discards partial words.
  byte_packer u_packer (
    .clock      (clock),
    .resetn     (resetn),
    .clear      (state == IDLE),
    .in_valid   (hs && (state == FILL)),
    .in_data    (bus.s_data),
    .word_valid (word_valid),
    .word       (word)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum;
`else
  assign chk_err = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state         <= IDLE;
      last_idx      <= '0;
      word_idx      <= '0;
      bus.bram_addr <= '0;
      bus.bram_din  <= '0;
      bus.bram_we   <= '0;
      bus.bram_en   <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      words_written <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum           <= '0;
      chk_err       <= 1'b0;
`endif
    end else begin
      bus.bram_en <= 1'b0;
      bus.bram_we <= '0;
      frame_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state         <= FILL;
            last_idx      <= frame_last;
            word_idx      <= '0;
            words_written <= '0;
            busy          <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            sum           <= '0;
            chk_err       <= 1'b0;
`endif
          end
        end
        FILL: begin
`ifdef LOADER_CHECKSUM_EN
          if (hs) sum <= sum + bus.s_data;
`endif
          if (word_valid) begin
            bus.bram_en   <= 1'b1;
            bus.bram_we   <= WE_ALL;
            bus.bram_din  <= DATA_W'(word);
            bus.bram_addr <= word_idx;
            word_idx      <= word_idx + ADDR_W'(1);
            words_written <= words_written + (ADDR_W+1)'(1);
            if (word_idx == last_idx) begin
`ifdef LOADER_CHECKSUM_EN
              state <= CHECK;
`else
              state <= DONE;
`endif
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        // The checksum byte completes the frame directly, so the pulse lands one cycle after it.
        CHECK: begin
          if (hs) begin
            chk_err    <= (bus.s_data != sum);
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
`endif
        DONE: begin
          frame_done <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_stream_loader.sv
// Bench for bram_stream_loader: a frame-level reference model checked every cycle,
// plus directed frames with hand-computed BRAM contents and latencies.
module tb_bram_stream_loader;
  import loader_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] frame_last = '0;
  logic          busy, frame_done, chk_err;
  logic [AW:0]   words_written;

  bram_stream_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  bram_stream_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock         (clk),
    .resetn        (resetn),
    .bus           (bus.slave),
    .start         (start),
    .frame_last    (frame_last),
    .busy          (busy),
    .frame_done    (frame_done),
    .words_written (words_written),
    .chk_err       (chk_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  int hs_cyc = 0;
  logic [7:0] drv_sum = '0;

  logic [AW+DW-1:0] exp_q[$];
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } wr_t;
  wr_t wlog[$];
  int  done_q[$];

  // frame-level model: which bytes are in flight and what the outputs must read
  bit            m_active = 0, m_wait = 0, m_check = 0;
  int            m_idx = 0, m_last = 0;
  logic [7:0]    m_bytes[$];
  logic [7:0]    m_sum = '0;
  logic          e_en = 0, e_done = 0, e_busy = 0, e_chk = 0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_din = '0;
  logic [AW:0]   e_ww = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Inputs change at posedge+1, so the negedge sees what the next edge will sample.
  always @(negedge clk) begin
    chk("s_ready", bus.s_ready, m_active);
    chk("bram_en", bus.bram_en, e_en);
    chk("bram_we", bus.bram_we, e_en ? 4'hF : 4'h0);
    chk("bram_addr", bus.bram_addr, e_addr);
    chk("bram_din", bus.bram_din, e_din);
    chk("frame_done", frame_done, e_done);
    chk("busy", busy, e_busy);
    chk("words_written", words_written, e_ww);
    chk("chk_err", chk_err, e_chk);
    if (bus.bram_en === 1'b1) begin
      wlog.push_back('{addr: bus.bram_addr, data: bus.bram_din, cyc: cyc + 1});
      chk("wr_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("wr_word", {bus.bram_addr, bus.bram_din}, exp_q.pop_front());
    end
    if (frame_done === 1'b1) done_q.push_back(cyc + 1);

    e_en   = 1'b0;
    e_done = 1'b0;
    if (!resetn) begin
      m_active = 0; m_wait = 0; m_check = 0;
      m_bytes.delete();
      e_addr = '0; e_din = '0; e_busy = 0; e_ww = '0; e_chk = 0;
    end else if (m_wait) begin
      e_done = 1'b1; e_busy = 1'b0; m_wait = 0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1; m_last = int'(frame_last); m_idx = 0; m_sum = '0;
        m_bytes.delete();
        e_ww = '0; e_busy = 1'b1; e_chk = 1'b0;
      end
    end else if (bus.s_valid) begin
      if (m_check) begin
        e_chk = (bus.s_data != m_sum);
        e_done = 1'b1; e_busy = 1'b0; m_active = 0; m_check = 0;
      end else begin
        m_bytes.push_back(bus.s_data);
        m_sum += bus.s_data;
        if (m_bytes.size() == 4) begin
          e_en   = 1'b1;
          e_addr = AW'(m_idx);
          e_din  = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
          m_bytes.delete();
          exp_q.push_back({e_addr, e_din});
          e_ww++;
          if (m_idx == m_last) begin
            m_active = CK; m_check = CK; m_wait = !CK;
          end
          m_idx++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int n, input logic with_start);
    resetn = 1'b0; start = with_start; bus.s_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
    resetn = 1'b1; start = 1'b0;
  endtask

  task automatic do_start(input logic [AW-1:0] last);
    start = 1'b1; frame_last = last; drv_sum = '0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic rdy;
    int   n;
    bus.s_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.s_valid = 1'b1; bus.s_data = b; n = 0;
    do begin
      @(negedge clk); rdy = bus.s_ready;
      @(posedge clk); #1; n++;
    end while (!rdy && n < 64);
    checks++;
    if (!rdy) begin
      errors++;
      $display("FAIL send_timeout: byte 0x%0h not accepted within %0d cycles", b, n);
    end
    hs_cyc = cyc;
    drv_sum += b;
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n0 = done_q.size();
    int n  = 0;
    bus.s_valid = 1'b0;
    while (done_q.size() == n0 && n < budget) begin @(posedge clk); #1; n++; end
    chk("done_seen", done_q.size() > n0, 1);
    @(posedge clk); #1;
  endtask

  task automatic finish_frame(input int budget);
    if (CK) send_byte(drv_sum, 0);
    wait_done(budget);
  endtask

  // ---------------- directed tests ----------------
  localparam logic [DW-1:0] T2_EXP [4] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};

  initial begin
    int         b0, nd, t_last;
    logic [7:0] v;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;

    // reset with start held high: reset must win
    do_reset(3, 1'b1);
    chk("rst_busy", busy, 0);
    chk("rst_ww", words_written, 0);
    chk("rst_ready", bus.s_ready, 0);

    // single-word frame
    b0 = wlog.size(); nd = done_q.size();
    do_start(10'd0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    t_last = hs_cyc;
    finish_frame(20);
    chk("t1_nwr", wlog.size() - b0, 1);
    chk("t1_addr", wlog[b0].addr, 0);
    chk("t1_data", wlog[b0].data, 32'h44332211);
    chk("t1_wr_lat", wlog[b0].cyc - t_last, 1);
`ifndef LOADER_CHECKSUM_EN
    chk("t1_done_lat", done_q[nd] - t_last, 2);
`endif
    chk("t1_ww", words_written, 1);

    // four words, continuous stream
    b0 = wlog.size();
    do_start(10'd3);
    for (int i = 0; i < 16; i++) send_byte(8'(i), 0);
    finish_frame(20);
    chk("t2_nwr", wlog.size() - b0, 4);
    for (int k = 0; k < 4; k++) begin
      chk("t2_addr", wlog[b0+k].addr, k);
      chk("t2_data", wlog[b0+k].data, T2_EXP[k]);
      if (k > 0) chk("t2_spacing", wlog[b0+k].cyc - wlog[b0+k-1].cyc, 4);
    end

    // full 1024-word frame with random valid gaps
    b0 = wlog.size();
    do_start(10'd1023);
    for (int i = 0; i < 4096; i++) begin
      v = 8'(i ^ (i >> 8));
      send_byte(v, $urandom_range(0, 2));
    end
    finish_frame(50);
    chk("t3_nwr", wlog.size() - b0, 1024);
    chk("t3_first_addr", wlog[b0].addr, 0);
    chk("t3_last_addr", wlog[wlog.size()-1].addr, 1023);
    chk("t3_ww", words_written, 1024);
    repeat (3) begin @(posedge clk); #1; end
    chk("t3_ready_after", bus.s_ready, 0);

    // reset two bytes into word 5, then restart cleanly
    do_start(10'd9);
    for (int i = 0; i < 22; i++) send_byte(8'(8'h80 + i), 0);
    do_reset(2, 1'b0);
    chk("t4_rst_addr", bus.bram_addr, 0);
    chk("t4_rst_din", bus.bram_din, 0);
    chk("t4_rst_ww", words_written, 0);
    chk("t4_rst_busy", busy, 0);
    b0 = wlog.size();
    do_start(10'd1);
    for (int i = 0; i < 8; i++) send_byte(8'(8'hA0 + i), 0);
    finish_frame(20);
    chk("t4_addr0", wlog[b0].addr, 0);
    chk("t4_data0", wlog[b0].data, 32'hA3A2A1A0);
    chk("t4_data1", wlog[b0+1].data, 32'hA7A6A5A4);

    // start pulsed mid-frame with a different length must be ignored
    b0 = wlog.size();
    do_start(10'd1);
    for (int i = 0; i < 4; i++) send_byte(8'(8'h50 + i), 0);
    start = 1'b1; frame_last = 10'd5;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 4; i < 8; i++) send_byte(8'(8'h50 + i), 0);
    finish_frame(20);
    chk("t5_nwr", wlog.size() - b0, 2);
    chk("t5_ww", words_written, 2);
    chk("t5_data1", wlog[b0+1].data, 32'h57565554);
    chk("t5_busy", busy, 0);

`ifdef LOADER_CHECKSUM_EN
    // good checksum, then bad checksum
    b0 = wlog.size();
    do_start(10'd0);
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
    send_byte(8'h0A, 0);
    wait_done(20);
    chk("t6_chk_ok", chk_err, 0);
    chk("t6_nwr", wlog.size() - b0, 1);
    nd = done_q.size();
    do_start(10'd0);
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
    t_last = cyc;
    send_byte(8'h0B, 0);
    t_last = hs_cyc;
    wait_done(20);
    chk("t6_chk_bad", chk_err, 1);
    chk("t6_done_pulsed", done_q.size() - nd, 1);
    chk("t6_done_lat", done_q[nd] - t_last, 1);
    repeat (3) begin @(posedge clk); #1; end
    chk("t6_chk_held", chk_err, 1);
`endif

    chk("exp_q_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
